// File: rtl/ps2_kbd_receiver_pkg.sv
// Shared definitions for the PS/2 keyboard receiver:
// frame constants, handshake states and a parity helper.
package ps2_kbd_receiver_pkg;

    localparam int   FRAME_BITS = 11;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        VALID,
        ACK
    } hs_state_t;

    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_kbd_receiver_fifo.sv
// Small circular FIFO holding received scancodes.
// Push and pop in the same cycle are both honoured, even when full.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  do_wr;
    logic                  do_rd;

    assign full  = (count == (DEPTH_LOG2+1)'(DEPTH));
    assign empty = (count == '0);
    assign do_wr = push && (!full || pop);
    assign do_rd = pop && !empty;
    assign dout  = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) begin
                wptr <= wptr + 1'b1;
            end
            if (do_rd) begin
                rptr <= rptr + 1'b1;
            end
            if (do_wr && !do_rd) begin
                count <= count + 1'b1;
            end else if (do_rd && !do_wr) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_kbd_receiver.sv
// PS/2 device-to-host receiver: pin conditioning, frame checking,
// scancode FIFO and the bus-side KBDready/KBDread handshake.
module ps2_kbd_receiver
    import ps2_kbd_receiver_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int DEPTH_LOG2     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       KBDread,
    output logic       KBDready,
    output logic [7:0] scancode,
    output logic       overflow,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic [FW-1:0] fcnt;
    logic          filt;
    logic          filt_q;
    logic          strobe;
    logic [3:0]    bitcnt;
    logic [9:0]    sr;
    logic [TW-1:0] tcnt;
    logic          last_bit;
    logic          frame_ok;
    logic          push;
    logic          pop;
    logic [7:0]    head;
    logic          full;
    logic          empty;
    hs_state_t     state;
    hs_state_t     state_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            fcnt      <= '0;
            filt      <= 1'b1;
            filt_q    <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            filt_q    <= filt;
            if (clk_sync[1] == filt) begin
                fcnt <= '0;
            end else if (fcnt == FW'(FILTER_LEN - 1)) begin
                filt <= clk_sync[1];
                fcnt <= '0;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    assign strobe   = filt_q && !filt;
    assign last_bit = strobe && (bitcnt == 4'(FRAME_BITS - 1));
    // sr[0] holds the start bit, sr[8:1] the data, sr[9] parity
    assign frame_ok = (sr[0] == START_BIT)
                   && (data_sync[1] == STOP_BIT)
                   && odd_parity_ok(sr[8:1], sr[9]);
    assign push     = last_bit && frame_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            bitcnt    <= '0;
            sr        <= '0;
            tcnt      <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            frame_err <= last_bit && !frame_ok;
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
            if (strobe) begin
                tcnt <= '0;
                if (last_bit) begin
                    bitcnt <= '0;
                    sr     <= '0;
                end else begin
                    bitcnt <= bitcnt + 1'b1;
                    sr     <= {data_sync[1], sr[9:1]};
                end
            end else if (bitcnt != '0) begin
                if (tcnt == TW'(TIMEOUT_CYCLES)) begin
                    bitcnt <= '0;
                    sr     <= '0;
                    tcnt   <= '0;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end else begin
                tcnt <= '0;
            end
        end
    end

    sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (sr[8:1]),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            scancode <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && state_nx == VALID) begin
                scancode <= head;
            end
        end
    end

    // ACK holds until KBDread drops, so a long read pops only once
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty && !KBDread) begin
                    state_nx = VALID;
                end
            end
            VALID: begin
                if (KBDread) begin
                    pop      = 1'b1;
                    state_nx = ACK;
                end
            end
            ACK: begin
                if (!KBDread) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign KBDready = (state == VALID);

endmodule

// File: tb/tb_ps2_kbd_receiver.sv
// Randomised and directed bench for ps2_kbd_receiver against
// a queue-based model of the keyboard byte stream.
module tb_ps2_kbd_receiver;

    localparam int FL   = 8;
    localparam int TO   = 2000;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic       KBDread;
    logic       KBDready;
    logic [7:0] scancode;
    logic       overflow;
    logic       frame_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int err_pulses = 0;
    int rise_cyc = -1;
    int fall_cyc = 0;
    logic rdy_d = 1'b0;

    logic [7:0] q[$];
    bit ovf_m;

    ps2_kbd_receiver #(
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TO),
        .DEPTH_LOG2     (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .KBDread   (KBDread),
        .KBDready  (KBDready),
        .scancode  (scancode),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (frame_err) err_pulses++;
        if (KBDready && !rdy_d) rise_cyc = cyc;
        rdy_d = KBDready;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input bit b);
        ps2_data = b;
        tick(HALF);
        ps2_clk = 1'b0;
        fall_cyc = cyc;
        tick(HALF);
        ps2_clk = 1'b1;
    endtask

    // kind: 0 good, 1 bad parity, 2 bad stop, 3 bad start
    task automatic send_frame(input logic [7:0] d, input int kind);
        logic [10:0] f;
        int e0;
        e0 = err_pulses;
        f[0]   = (kind == 3);
        f[8:1] = d;
        f[9]   = ~^d ^ (kind == 1);
        f[10]  = (kind != 2);
        for (int i = 0; i < 11; i++) send_bit(f[i]);
        tick(HALF);
        if (kind == 0) begin
            if (q.size() < 8) q.push_back(d);
            else ovf_m = 1'b1;
        end
        check("frame_err", err_pulses - e0, (kind == 0) ? 0 : 1);
    endtask

    task automatic read_one(input int hold);
        logic [7:0] exp;
        int n;
        n = 0;
        while (!KBDready && n < 100) begin
            tick(1);
            n++;
        end
        check("ready_wait", KBDready, 1);
        exp = q.pop_front();
        check("scancode", scancode, exp);
        KBDread = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick(1);
            check("ready_in_ack", KBDready, 0);
        end
        KBDread = 1'b0;
        tick(1);
    endtask

    task automatic drain();
        while (q.size() > 0) read_one($urandom_range(1, 4));
        tick(6);
        check("drained_ready", KBDready, 0);
        check("overflow", overflow, ovf_m);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        q.delete();
        ovf_m = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        KBDread = 1'b0;
        ovf_m = 1'b0;
        tick(3);
        check("rst_ready", KBDready, 0);
        check("rst_scancode", scancode, 0);
        check("rst_overflow", overflow, 0);
        check("rst_frame_err", frame_err, 0);
        rst = 1'b0;
        tick(4);

        rise_cyc = -1;
        send_frame(8'h1C, 0);
        check("latency", rise_cyc - fall_cyc, FL + 4);
        drain();

        send_frame(8'h1C, 1);
        check("bad_par_ready", KBDready, 0);

        send_frame(8'hF0, 0);
        send_frame(8'h1C, 0);
        read_one(5);
        drain();

        for (int i = 1; i <= 9; i++) send_frame(8'(i), 0);
        check("ovf_set", overflow, 1);
        drain();

        for (int i = 0; i < 5; i++) send_bit(i[0]);
        tick(TO + 200);
        send_frame(8'h5A, 0);
        drain();

        for (int i = 0; i < 7; i++) send_bit(1'b0);
        do_reset();
        tick(4);
        send_frame(8'h29, 0);
        check("after_rst_ovf", overflow, 0);
        drain();

        for (int it = 0; it < 30; it++) begin
            int k;
            k = $urandom_range(0, 9);
            send_frame(8'($urandom), (k < 3) ? k + 1 : 0);
            if ($urandom_range(0, 2) == 0) drain();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
